// File: rtl/hyper_titan_axil_demux.sv
// AXI-Lite 1-to-NUM_MP demultiplexer with base/mask address decode, in-order
// response tracking per direction and an internal DECERR responder for unmapped addresses.

package hyper_titan_axil_pkg;
    typedef struct packed {
        logic [31:0] aw_addr;
        logic [2:0]  aw_prot;
        logic        aw_valid;
        logic [31:0] w_data;
        logic [3:0]  w_strb;
        logic        w_valid;
        logic        b_ready;
        logic [31:0] ar_addr;
        logic [2:0]  ar_prot;
        logic        ar_valid;
        logic        r_ready;
    } pl_s_axil_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        logic [1:0]  b_resp;
        logic        ar_ready;
        logic        r_valid;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
    } pl_s_axil_resp_t;
endpackage

module hyper_titan_axil_demux
    import hyper_titan_axil_pkg::*;
#(
    parameter int NUM_MP = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MAX_OUTST = 4,
    parameter logic [NUM_MP-1:0][AW-1:0] ADDR_BASE = '0,
    parameter logic [NUM_MP-1:0][AW-1:0] ADDR_MASK = '0,
    parameter type req_t = pl_s_axil_req_t,
    parameter type resp_t = pl_s_axil_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  req_t  s_req_i,
    output resp_t s_resp_o,
    output req_t  m_req_o [NUM_MP],
    input  resp_t m_resp_i [NUM_MP]
);

    localparam int IDX_W = $clog2(NUM_MP + 1);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [IDX_W-1:0] ERR = IDX_W'(NUM_MP);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [DW-1:0] ERR_DATA = '0;

    logic [IDX_W-1:0] wr_tgt, rd_tgt, aw_dec, ar_dec, w_head;
    logic [CNT_W-1:0] wr_cnt, rd_cnt, fifo_cnt, err_b_cnt, err_r_cnt;
    logic [PTR_W-1:0] fifo_wr, fifo_rd;
    logic [IDX_W-1:0] fifo_mem [MAX_OUTST];
    logic aw_allow, ar_allow, w_open, b_open, r_open;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    resp_t s_resp;

    // Lowest matching index wins; no match selects the DECERR responder.
    function automatic logic [IDX_W-1:0] decode(input logic [AW-1:0] addr);
        logic [IDX_W-1:0] sel;
        sel = ERR;
        for (int i = NUM_MP - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASK[i]) == ADDR_BASE[i]) sel = IDX_W'(i);
        end
        return sel;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign aw_dec = decode(AW'(s_req_i.aw_addr));
    assign ar_dec = decode(AW'(s_req_i.ar_addr));
    assign w_head = fifo_mem[fifo_rd];

    // A new target is only admitted once every response of the previous one has returned.
    assign aw_allow = !rst_i && (fifo_cnt != CNT_MAX) &&
                      ((wr_cnt == '0) || ((aw_dec == wr_tgt) && (wr_cnt < CNT_MAX)));
    assign ar_allow = !rst_i &&
                      ((rd_cnt == '0) || ((ar_dec == rd_tgt) && (rd_cnt < CNT_MAX)));
    assign w_open = !rst_i && (fifo_cnt != '0);
    assign b_open = !rst_i && (wr_cnt != '0);
    assign r_open = !rst_i && (rd_cnt != '0);

    always_comb begin
        s_resp = '0;
        for (int i = 0; i < NUM_MP; i++) begin
            m_req_o[i] = s_req_i;
            m_req_o[i].aw_valid = 1'b0;
            m_req_o[i].w_valid  = 1'b0;
            m_req_o[i].b_ready  = 1'b0;
            m_req_o[i].ar_valid = 1'b0;
            m_req_o[i].r_ready  = 1'b0;
        end
        if (aw_allow && s_req_i.aw_valid) begin
            if (aw_dec == ERR) s_resp.aw_ready = 1'b1;
            for (int i = 0; i < NUM_MP; i++) begin
                if (aw_dec == IDX_W'(i)) begin
                    m_req_o[i].aw_valid = 1'b1;
                    s_resp.aw_ready = m_resp_i[i].aw_ready;
                end
            end
        end
        if (w_open && s_req_i.w_valid) begin
            if (w_head == ERR) s_resp.w_ready = 1'b1;
            for (int i = 0; i < NUM_MP; i++) begin
                if (w_head == IDX_W'(i)) begin
                    m_req_o[i].w_valid = 1'b1;
                    s_resp.w_ready = m_resp_i[i].w_ready;
                end
            end
        end
        if (b_open) begin
            if (wr_tgt == ERR) begin
                s_resp.b_valid = (err_b_cnt != '0);
                s_resp.b_resp  = 2'b11;
            end
            for (int i = 0; i < NUM_MP; i++) begin
                if (wr_tgt == IDX_W'(i)) begin
                    s_resp.b_valid = m_resp_i[i].b_valid;
                    s_resp.b_resp  = m_resp_i[i].b_resp;
                    m_req_o[i].b_ready = s_req_i.b_ready;
                end
            end
        end
        if (ar_allow && s_req_i.ar_valid) begin
            if (ar_dec == ERR) s_resp.ar_ready = 1'b1;
            for (int i = 0; i < NUM_MP; i++) begin
                if (ar_dec == IDX_W'(i)) begin
                    m_req_o[i].ar_valid = 1'b1;
                    s_resp.ar_ready = m_resp_i[i].ar_ready;
                end
            end
        end
        if (r_open) begin
            if (rd_tgt == ERR) begin
                s_resp.r_valid = (err_r_cnt != '0);
                s_resp.r_data  = ERR_DATA;
                s_resp.r_resp  = 2'b11;
            end
            for (int i = 0; i < NUM_MP; i++) begin
                if (rd_tgt == IDX_W'(i)) begin
                    s_resp.r_valid = m_resp_i[i].r_valid;
                    s_resp.r_data  = m_resp_i[i].r_data;
                    s_resp.r_resp  = m_resp_i[i].r_resp;
                    m_req_o[i].r_ready = s_req_i.r_ready;
                end
            end
        end
    end

    assign s_resp_o = s_resp;
    assign aw_hs = s_req_i.aw_valid && s_resp.aw_ready;
    assign w_hs  = s_req_i.w_valid  && s_resp.w_ready;
    assign b_hs  = s_resp.b_valid   && s_req_i.b_ready;
    assign ar_hs = s_req_i.ar_valid && s_resp.ar_ready;
    assign r_hs  = s_resp.r_valid   && s_req_i.r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_tgt    <= '0;
            rd_tgt    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            fifo_cnt  <= '0;
            fifo_wr   <= '0;
            fifo_rd   <= '0;
            err_b_cnt <= '0;
            err_r_cnt <= '0;
        end else begin
            if (aw_hs) wr_tgt <= aw_dec;
            if (ar_hs) rd_tgt <= ar_dec;
            wr_cnt   <= wr_cnt + CNT_W'(aw_hs) - CNT_W'(b_hs);
            rd_cnt   <= rd_cnt + CNT_W'(ar_hs) - CNT_W'(r_hs);
            fifo_cnt <= fifo_cnt + CNT_W'(aw_hs) - CNT_W'(w_hs);
            if (aw_hs) fifo_wr <= ptr_next(fifo_wr);
            if (w_hs)  fifo_rd <= ptr_next(fifo_rd);
            // DECERR responses become visible the cycle after W / AR is taken.
            err_b_cnt <= err_b_cnt + CNT_W'(w_hs && (w_head == ERR))
                                   - CNT_W'(b_hs && (wr_tgt == ERR));
            err_r_cnt <= err_r_cnt + CNT_W'(ar_hs && (ar_dec == ERR))
                                   - CNT_W'(r_hs && (rd_tgt == ERR));
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_hs) fifo_mem[fifo_wr] <= aw_dec;
    end

endmodule

// File: tb/tb_hyper_titan_axil_demux.sv
// Bench for hyper_titan_axil_demux: decode table, directed ordering/stall sequences,
// and randomized single transactions against a behavioural address-map model.

module tb_hyper_titan_axil_demux;
    import hyper_titan_axil_pkg::*;

    localparam int NP = 4;
    localparam int BUDGET = 50;
    localparam logic [NP-1:0][31:0] BASE = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NP-1:0][31:0] MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    pl_s_axil_req_t  s_req;
    pl_s_axil_resp_t s_resp;
    pl_s_axil_req_t  m_req [NP];
    pl_s_axil_resp_t m_resp [NP];

    logic [3:0] aw_en = 4'hF, w_en = 4'hF, ar_en = 4'hF, r_en = 4'hF;
    int b_cnt [NP];
    logic [2:0] r_wp [NP];
    logic [2:0] r_rp [NP];
    logic [31:0] r_mem [NP][8];
    logic [35:0] wlog [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hyper_titan_axil_demux #(
        .NUM_MP(NP), .AW(32), .DW(32), .MAX_OUTST(4),
        .ADDR_BASE(BASE), .ADDR_MASK(MASK)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_i(s_req), .s_resp_o(s_resp),
        .m_req_o(m_req), .m_resp_i(m_resp)
    );

    function automatic logic [31:0] slave_data(int p, logic [31:0] a);
        return a ^ (32'h0101_0101 * 32'(p + 1));
    endfunction

    function automatic int ref_port(logic [31:0] a);
        for (int i = 0; i < NP; i++) if ((a & MASK[i]) == BASE[i]) return i;
        return NP;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: return {16'h0000, r[15:0]};
            1: return {16'h1000, r[15:0]};
            2: return {16'h2000, r[15:0]};
            3: return {4'h1, r[27:0]};
            default: return r;
        endcase
    endfunction

    // Downstream slaves: always ready (per-port enables), one B per W, R data derived from address.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            m_resp[i] = '0;
            m_resp[i].aw_ready = aw_en[i];
            m_resp[i].w_ready  = w_en[i];
            m_resp[i].ar_ready = ar_en[i];
            m_resp[i].b_valid  = (b_cnt[i] != 0);
            m_resp[i].r_valid  = (r_wp[i] != r_rp[i]) && r_en[i];
            m_resp[i].r_data   = r_mem[i][r_rp[i]];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                b_cnt[i] <= 0;
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (m_req[i].w_valid && m_resp[i].w_ready) wlog.push_back({4'(i), m_req[i].w_data});
                b_cnt[i] <= b_cnt[i] + ((m_req[i].w_valid && m_resp[i].w_ready) ? 1 : 0)
                                     - ((m_resp[i].b_valid && m_req[i].b_ready) ? 1 : 0);
                if (m_req[i].ar_valid && m_resp[i].ar_ready) begin
                    r_mem[i][r_wp[i]] <= slave_data(i, m_req[i].ar_addr);
                    r_wp[i] <= r_wp[i] + 3'd1;
                end
                if (m_resp[i].r_valid && m_req[i].r_ready) r_rp[i] <= r_rp[i] + 3'd1;
            end
        end
    end

    function automatic logic [3:0] valids(int kind);
        logic [3:0] v;
        for (int i = 0; i < NP; i++) begin
            case (kind)
                0: v[i] = m_req[i].aw_valid;
                1: v[i] = m_req[i].w_valid;
                default: v[i] = m_req[i].ar_valid;
            endcase
        end
        return v;
    endfunction

    function automatic logic [24:0] ctl_bits();
        logic [24:0] v;
        for (int i = 0; i < NP; i++)
            v[i*5 +: 5] = {m_req[i].aw_valid, m_req[i].w_valid, m_req[i].b_ready,
                           m_req[i].ar_valid, m_req[i].r_ready};
        v[24:20] = {s_resp.aw_ready, s_resp.w_ready, s_resp.b_valid, s_resp.ar_ready, s_resp.r_valid};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake expected one within %0d cycles", name, BUDGET);
    endtask

    // All transfer tasks start and end 1 time unit after a rising edge.
    task automatic aw_xfer(input logic [31:0] addr);
        int n = 0;
        s_req.aw_addr = addr; s_req.aw_prot = 3'b000; s_req.aw_valid = 1'b1;
        #1;
        while (!s_resp.aw_ready && n < BUDGET) begin @(posedge clk); #2; n++; end
        if (!s_resp.aw_ready) timeout("aw");
        @(posedge clk); #1;
        s_req.aw_valid = 1'b0;
    endtask

    task automatic w_xfer(input logic [31:0] data);
        int n = 0;
        s_req.w_data = data; s_req.w_strb = 4'hF; s_req.w_valid = 1'b1;
        #1;
        while (!s_resp.w_ready && n < BUDGET) begin @(posedge clk); #2; n++; end
        if (!s_resp.w_ready) timeout("w");
        @(posedge clk); #1;
        s_req.w_valid = 1'b0;
    endtask

    task automatic ar_xfer(input logic [31:0] addr);
        int n = 0;
        s_req.ar_addr = addr; s_req.ar_prot = 3'b000; s_req.ar_valid = 1'b1;
        #1;
        while (!s_resp.ar_ready && n < BUDGET) begin @(posedge clk); #2; n++; end
        if (!s_resp.ar_ready) timeout("ar");
        @(posedge clk); #1;
        s_req.ar_valid = 1'b0;
    endtask

    task automatic b_take(output logic [1:0] resp);
        int n = 0;
        s_req.b_ready = 1'b1;
        #1;
        while (!s_resp.b_valid && n < BUDGET) begin @(posedge clk); #2; n++; end
        if (!s_resp.b_valid) timeout("b");
        resp = s_resp.b_resp;
        @(posedge clk); #1;
        s_req.b_ready = 1'b0;
    endtask

    task automatic r_take(output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        s_req.r_ready = 1'b1;
        #1;
        while (!s_resp.r_valid && n < BUDGET) begin @(posedge clk); #2; n++; end
        if (!s_resp.r_valid) timeout("r");
        data = s_resp.r_data;
        resp = s_resp.r_resp;
        @(posedge clk); #1;
        s_req.r_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          port;
    } dec_vec_t;

    dec_vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, data;
        logic [1:0]  rs;
        logic [31:0] addr;
        logic [31:0] q_addr [$];
        int p;

        vecs[0] = '{32'h0000_0010, 0};
        vecs[1] = '{32'h1000_0004, 1};
        vecs[2] = '{32'h1000_FFFC, 1};
        vecs[3] = '{32'h1001_0000, 3};
        vecs[4] = '{32'h2000_0008, 2};
        vecs[5] = '{32'h2001_0000, 4};
        vecs[6] = '{32'hF000_0000, 4};
        vecs[7] = '{32'h1FFF_FFFC, 3};

        // Reset with every upstream valid/ready asserted.
        s_req = '0;
        s_req.aw_valid = 1'b1; s_req.w_valid = 1'b1; s_req.ar_valid = 1'b1;
        s_req.b_ready = 1'b1; s_req.r_ready = 1'b1;
        s_req.aw_addr = 32'h1000_0000; s_req.ar_addr = 32'h1000_0000;
        repeat (3) begin @(posedge clk); #2; chk("reset_hold", ctl_bits(), 0); end
        rst = 1'b0;
        s_req = '0;
        @(posedge clk); #1;
        chk("reset_after_ctl", ctl_bits(), 0);
        chk("reset_after_state", {dut.wr_cnt, dut.rd_cnt, dut.fifo_cnt, dut.wr_tgt, dut.rd_tgt}, 0);

        // Decode table through single reads.
        for (int k = 0; k < 8; k++) begin
            s_req.ar_addr = vecs[k].addr; s_req.ar_valid = 1'b1;
            #1;
            chk("dec_sel", valids(2), (vecs[k].port < NP) ? (4'b1 << vecs[k].port) : 4'b0);
            chk("dec_ar_ready", s_resp.ar_ready, 1);
            @(posedge clk); #1;
            s_req.ar_valid = 1'b0;
            r_take(d, rs);
            chk("dec_r_data", d, (vecs[k].port < NP) ? slave_data(vecs[k].port, vecs[k].addr) : 32'h0);
            chk("dec_r_resp", rs, (vecs[k].port < NP) ? 2'b00 : 2'b11);
        end

        // Write to port 1: AW and W appear on port 1 only; B OKAY.
        s_req.aw_addr = 32'h1000_0004; s_req.aw_valid = 1'b1;
        #1;
        chk("wr1_aw_sel", valids(0), 4'b0010);
        @(posedge clk); #1;
        s_req.aw_valid = 1'b0;
        s_req.w_data = 32'hCAFE_0001; s_req.w_strb = 4'hF; s_req.w_valid = 1'b1;
        #1;
        chk("wr1_w_sel", valids(1), 4'b0010);
        @(posedge clk); #1;
        s_req.w_valid = 1'b0;
        b_take(rs);
        chk("wr1_b_resp", rs, 2'b00);
        chk("wr1_cnt", dut.wr_cnt, 0);
        chk("wr1_wlog", (wlog.size() == 1) ? wlog.pop_front() : 36'hF_FFFF_FFFF, {4'd1, 32'hCAFE_0001});

        // Unmapped read: R one cycle after the AR handshake, no downstream valids.
        s_req.ar_addr = 32'hF000_0000; s_req.ar_valid = 1'b1;
        #1;
        chk("err_ar_ready", s_resp.ar_ready, 1);
        chk("err_ar_sel", valids(2), 0);
        chk("err_r_before", s_resp.r_valid, 0);
        @(posedge clk); #1;
        s_req.ar_valid = 1'b0;
        chk("err_r_lat", {s_resp.r_valid, s_resp.r_data, s_resp.r_resp}, {1'b1, 32'h0, 2'b11});
        r_take(d, rs);

        // Unmapped write: W sunk, B DECERR next cycle and held until b_ready.
        aw_xfer(32'hF000_0000);
        w_xfer(32'h1234_5678);
        chk("err_b_lat", {s_resp.b_valid, s_resp.b_resp}, {1'b1, 2'b11});
        @(posedge clk); #1;
        chk("err_b_hold", s_resp.b_valid, 1);
        b_take(rs);
        chk("err_b_resp", rs, 2'b11);
        chk("err_w_none", wlog.size(), 0);

        // Four outstanding reads to port 0, fifth stalls until one R retires.
        for (int k = 0; k < 4; k++) begin
            ar_xfer(32'h0000_0100 + 32'(k * 4));
            q_addr.push_back(32'h0000_0100 + 32'(k * 4));
        end
        s_req.ar_addr = 32'h0000_0110; s_req.ar_valid = 1'b1;
        #1;
        chk("sat_stall0", {s_resp.ar_ready, valids(2)}, 0);
        @(posedge clk); #2;
        chk("sat_stall1", {s_resp.ar_ready, valids(2)}, 0);
        s_req.r_ready = 1'b1;
        #1;
        chk("sat_stall_rhs", {s_resp.ar_ready, s_resp.r_valid}, 2'b01);
        chk("sat_r0_data", s_resp.r_data, slave_data(0, q_addr.pop_front()));
        @(posedge clk); #1;
        s_req.r_ready = 1'b0;
        #1;
        chk("sat_admit", s_resp.ar_ready, 1);
        @(posedge clk); #1;
        s_req.ar_valid = 1'b0;
        q_addr.push_back(32'h0000_0110);
        for (int k = 0; k < 4; k++) begin
            r_take(d, rs);
            chk("sat_r_order", d, slave_data(0, q_addr.pop_front()));
        end

        // Port switch waits for the previous target to drain.
        r_en[0] = 1'b0;
        ar_xfer(32'h0000_0200);
        s_req.ar_addr = 32'h2000_0010; s_req.ar_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("sw_stall", {s_resp.ar_ready, m_req[2].ar_valid}, 0);
            @(posedge clk); #2;
        end
        r_en[0] = 1'b1;
        s_req.ar_valid = 1'b0;
        r_take(d, rs);
        chk("sw_r0", d, slave_data(0, 32'h0000_0200));
        s_req.ar_valid = 1'b1;
        #1;
        chk("sw_admit", {s_resp.ar_ready, valids(2)}, {1'b1, 4'b0100});
        @(posedge clk); #1;
        s_req.ar_valid = 1'b0;
        r_take(d, rs);
        chk("sw_r2", d, slave_data(2, 32'h2000_0010));

        // W ordering through the target FIFO.
        s_req.w_data = 32'hAAAA_0001; s_req.w_valid = 1'b1;
        #1;
        chk("w_before_aw", {s_resp.w_ready, valids(1)}, 0);
        @(posedge clk); #1;
        s_req.w_valid = 1'b0;
        aw_xfer(32'h2000_0000);
        repeat (5) begin @(posedge clk); #1; end
        s_req.aw_addr = 32'h2000_0004; s_req.aw_valid = 1'b1;
        s_req.w_data = 32'hAAAA_0001; s_req.w_valid = 1'b1;
        #1;
        chk("wf_both_ready", {s_resp.aw_ready, s_resp.w_ready, valids(1)}, {2'b11, 4'b0100});
        @(posedge clk); #1;
        s_req.aw_valid = 1'b0; s_req.w_valid = 1'b0;
        w_xfer(32'hBBBB_0002);
        chk("wf_first", (wlog.size() > 0) ? wlog.pop_front() : 36'hF_FFFF_FFFF, {4'd2, 32'hAAAA_0001});
        chk("wf_second", (wlog.size() > 0) ? wlog.pop_front() : 36'hF_FFFF_FFFF, {4'd2, 32'hBBBB_0002});
        b_take(rs); chk("wf_b0", rs, 2'b00);
        b_take(rs); chk("wf_b1", rs, 2'b00);

        // Reset with two writes outstanding, then a fresh write.
        aw_xfer(32'h1000_0010);
        aw_xfer(32'h1000_0014);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ctl", ctl_bits(), 0);
        chk("mid_rst_cnt", {dut.wr_cnt, dut.fifo_cnt}, 0);
        aw_xfer(32'h1000_0020);
        w_xfer(32'hD00D_0003);
        b_take(rs);
        chk("mid_rst_b", rs, 2'b00);
        chk("mid_rst_w", (wlog.size() == 1) ? wlog.pop_front() : 36'hF_FFFF_FFFF, {4'd1, 32'hD00D_0003});

        // Randomized single transactions against the address-map model.
        for (int k = 0; k < 40; k++) begin
            addr = rand_addr();
            p = ref_port(addr);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                aw_xfer(addr);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                w_xfer(data);
                b_take(rs);
                chk("rnd_b_resp", rs, (p < NP) ? 2'b00 : 2'b11);
                if (p < NP)
                    chk("rnd_w_route", (wlog.size() == 1) ? wlog.pop_front() : 36'hF_FFFF_FFFF, {4'(p), data});
                else
                    chk("rnd_w_none", wlog.size(), 0);
            end else begin
                ar_xfer(addr);
                r_take(d, rs);
                chk("rnd_r", {d, rs}, (p < NP) ? {slave_data(p, addr), 2'b00} : {32'h0, 2'b11});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
